// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types, constants and spawn helper for the whack-a-mole controller
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int          TIMER_W   = 6;
  localparam logic [5:0]  SCORE_MAX = 6'd63;
  // Fibonacci taps for x^8+x^6+x^5+x^4+1, bits 7,5,4,3 of a left-shifting register
  localparam logic [7:0]  LFSR_TAPS = 8'hB8;

  // Pick a mole index from the random byte, stepping past the currently lit mole
  function automatic logic [2:0] pick_idx(input logic [7:0] rnd, input logic [7:0] lit,
                                          input int n);
    int i;
    i = int'(rnd) % n;
    if (lit[3'(i)])
      i = (i + 1) % n;
    return 3'(i);
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// rtl/mole_lfsr.sv - free-running seedable 8-bit Fibonacci LFSR
module mole_lfsr
  import game_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] rnd
);

  logic feedback;

  assign feedback = ^(rnd & LFSR_TAPS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rnd <= SEED;
    else
      rnd <= {rnd[6:0], feedback};
  end

endmodule

// File: rtl/game_controller.sv
// rtl/game_controller.sv - whack-a-mole game sequencing FSM with timer, score and mole pattern
module game_controller
  import game_pkg::*;
#(
  parameter int         NUM_MOLES    = 4,
  parameter int         GAME_SECONDS = 30,
  parameter int         MOLE_TICKS   = 3,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 tick_1hz,
  input  logic                 tick_mole,
  input  logic [NUM_MOLES-1:0] hit,
  output logic [NUM_MOLES-1:0] mole,
  output logic [TIMER_W-1:0]   timer,
  output logic [5:0]           score,
  output logic                 playing,
  output logic                 game_over
);

  localparam logic [TIMER_W-1:0]   TIMER_INIT = TIMER_W'(GAME_SECONDS);
  localparam logic [7:0]           AGE_LAST   = 8'(MOLE_TICKS - 1);
  localparam logic [NUM_MOLES-1:0] ONE_MOLE   = {{(NUM_MOLES-1){1'b0}}, 1'b1};

  state_t               state, state_n;
  logic [TIMER_W-1:0]   timer_n;
  logic [5:0]           score_n;
  logic [NUM_MOLES-1:0] mole_n, hit_q, hit_rise;
  logic [7:0]           age, age_n, rnd;
  logic                 start_q, start_rise, valid_hit;
  logic [2:0]           spawn_idx;

  mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .rnd   (rnd)
  );

  assign start_rise = start & ~start_q;
  assign hit_rise   = hit & ~hit_q;
  assign valid_hit  = |(hit_rise & mole);
  assign spawn_idx  = pick_idx(rnd, 8'(mole), NUM_MOLES);

  always_comb begin
    state_n = state;
    timer_n = timer;
    score_n = score;
    mole_n  = mole;
    age_n   = age;
    case (state)
      IDLE: begin
        if (start_rise) begin
          state_n = PLAY;
          timer_n = TIMER_INIT;
          score_n = '0;
          mole_n  = '0;
          age_n   = '0;
        end
      end
      PLAY: begin
        // A valid hit takes precedence over any mole tick in the same cycle
        if (valid_hit) begin
          score_n = (score == SCORE_MAX) ? score : score + 6'd1;
          mole_n  = '0;
          age_n   = '0;
        end else if (tick_mole) begin
          if (mole == '0 || age == AGE_LAST) begin
            mole_n = ONE_MOLE << spawn_idx;
            age_n  = '0;
          end else begin
            age_n = age + 8'd1;
          end
        end
        if (tick_1hz) begin
          if (timer == TIMER_W'(1)) begin
            state_n = OVER;
            timer_n = '0;
            mole_n  = '0;
            age_n   = '0;
          end else begin
            timer_n = timer - TIMER_W'(1);
          end
        end
      end
      OVER: begin
        timer_n = '0;
        mole_n  = '0;
        age_n   = '0;
        if (start_rise) begin
          state_n = PLAY;
          timer_n = TIMER_INIT;
          score_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = TIMER_INIT;
        score_n = '0;
        mole_n  = '0;
        age_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= TIMER_INIT;
      score     <= '0;
      mole      <= '0;
      age       <= '0;
      start_q   <= 1'b0;
      hit_q     <= '0;
      playing   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      score     <= score_n;
      mole      <= mole_n;
      age       <= age_n;
      start_q   <= start;
      hit_q     <= hit;
      playing   <= (state_n == PLAY);
      game_over <= (state_n == OVER);
    end
  end

endmodule
